adder_sweep_scheduler: RTL
==========================

Name: adder_sweep_scheduler

Overview:
- Sequences one shared Adder64to1 row-reduction instance across all NUM_SPINS rows of the coupling/phase matrix.
- Fetches one row per cycle from the row memory and times the adder enable.
- Captures each row sum into a row-sum buffer, then fires system_adder once to produce the total energy.
- Sits between the row memory, the two adder instances and the annealing control FSM, which issues start and consumes done/energy.

Parameters:
- NUM_SPINS, 64, rows per sweep; equals adder fan-in.
- NUM_SPINS_EXP, 6, log2(NUM_SPINS).
- IN_W, NL_OUT_PHASE_BITWIDTH, element width into the row adder.
- ADD_LAT, 1, register latency of each adder (row and system), >=1.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  request a sweep; sampled only in IDLE
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse; energy valid
- row_rd_en  out  1  row memory read strobe; fixed 1-cycle read latency
- row_rd_addr  out  NUM_SPINS_EXP  row index
- row_add_ena  out  1  ena to the row adder
- row_sum  in  IN_W+NUM_SPINS_EXP  row adder output
- sys_matrix  out  NUM_SPINS x (IN_W+NUM_SPINS_EXP)  row-sum buffer; drives the system adder input_matrix
- sys_add_ena  out  1  ena to the system adder
- sys_sum  in  IN_W+2*NUM_SPINS_EXP  system adder output
- energy  out  IN_W+2*NUM_SPINS_EXP  latched sweep total

Behaviour:
- Reset values: state IDLE; all outputs 0; sys_matrix entries 0; energy 0.
- States and transitions:
  - IDLE -> FETCH on start.
  - FETCH -> DRAIN after issuing addr NUM_SPINS-1.
  - DRAIN -> SYS when the last row is captured.
  - SYS -> WAIT_SYS after one cycle.
  - WAIT_SYS -> DONE when sys_sum is captured.
  - DONE -> IDLE.
- FETCH: row_rd_en=1 every cycle; row_rd_addr counts 0..NUM_SPINS-1, one per cycle, no gaps.
- row_add_ena is row_rd_en delayed 1 cycle, aligned with the memory data.
- Capture pipeline: valid+index shift chain of depth 1+ADD_LAT; on valid, sys_matrix[index] <= row_sum.
- SYS: sys_add_ena=1 for exactly one cycle. sys_matrix is held stable from SYS through the sys_sum capture.
- sys_sum is captured into energy ADD_LAT cycles after SYS.
- done=1 in DONE only; energy holds until the next capture.
- Timing, with start sampled at cycle 0:
  - addr k issued at cycle 1+k.
  - row k captured at cycle 2+ADD_LAT+k.
  - SYS at cycle NUM_SPINS+2+ADD_LAT.
  - done at cycle NUM_SPINS+3+2*ADD_LAT (69 for defaults).
- Widths: all arithmetic is unsigned; no truncation (row sum IN_W+NUM_SPINS_EXP, total IN_W+2*NUM_SPINS_EXP).
- Boundaries:
  - start while busy: ignored, not queued.
  - start held high continuously: a new sweep begins in the cycle after DONE; back-to-back sweeps are spaced exactly 1 IDLE cycle.
  - reset mid-sweep, any state: next cycle is IDLE with all outputs and the buffer zeroed; in-flight captures are discarded; no done pulse.
  - reset and start in the same cycle: reset wins.
  - Address counter wraps to 0 only on entering FETCH, never mid-sweep.
  - Outside their active cycles, row_add_ena and sys_add_ena are 0, so the adders output 0.

Optional Feature:
- Macro: ENERGY_MIN_TRACK_EN.
- Defined:
  - Adds outputs min_energy (IN_W+2*NUM_SPINS_EXP, reset value all-ones) and min_update (1).
  - In the DONE cycle, if energy < min_energy, then min_energy <= energy and min_update pulses with done.
  - A tie does not update.
  - min_energy survives sweeps; only reset clears it.
- Undefined: neither port exists; there is no comparator and no min register.

Test Plan:
- Defaults; memory returns all elements =1 for every row; start pulse at cycle 0 -> addr 0..63 on cycles 1..64; every sys_matrix entry =64; done at cycle 69; energy=4096.
- Row k elements all = k -> sys_matrix[k]=64*k; energy=64*2016=129024; row order verified.
- start pulsed at cycles 10 and 40 of a sweep -> ignored; exactly one done; busy continuous.
- reset asserted at cycle 30 during FETCH -> busy=0 and sys_matrix all 0 next cycle; no done; a fresh start then completes normally in 69 cycles.
- start held high for 3 sweeps -> done pulses spaced 70 cycles apart; energy updates each time.
- ENERGY_MIN_TRACK_EN defined; sweep energies 4096, 129024, 4096, 64 -> min_update pulses on sweeps 1 and 4 only; final min_energy=64.

Source files
------------

// File: rtl/adder_sweep_scheduler_if.sv
// Bus between the sweep scheduler and its neighbours: the annealing control
// FSM (start/busy/done/energy), the row memory, and the two adder instances.
// The master side is the scheduler; the slave side is the surrounding logic.
// ENERGY_MIN_TRACK_EN adds the running-minimum outputs.
interface adder_sweep_scheduler_if #(
  parameter int NUM_SPINS     = 64,
  parameter int NUM_SPINS_EXP = 6,
  parameter int IN_W          = 8
);
  localparam int ROW_W = IN_W + NUM_SPINS_EXP;
  localparam int TOT_W = IN_W + 2 * NUM_SPINS_EXP;

  // Control FSM side
  logic                              start;
  logic                              busy;
  logic                              done;
  logic [TOT_W-1:0]                  energy;
  // Row memory side
  logic                              row_rd_en;
  logic [NUM_SPINS_EXP-1:0]          row_rd_addr;
  // Row adder side
  logic                              row_add_ena;
  logic [ROW_W-1:0]                  row_sum;
  // System adder side
  logic [NUM_SPINS-1:0][ROW_W-1:0]   sys_matrix;
  logic                              sys_add_ena;
  logic [TOT_W-1:0]                  sys_sum;
`ifdef ENERGY_MIN_TRACK_EN
  logic [TOT_W-1:0]                  min_energy;
  logic                              min_update;
`endif

  modport master (
    input  start, row_sum, sys_sum,
    output busy, done, energy, row_rd_en, row_rd_addr, row_add_ena,
           sys_matrix, sys_add_ena
`ifdef ENERGY_MIN_TRACK_EN
    , output min_energy, min_update
`endif
  );

  modport slave (
    output start, row_sum, sys_sum,
    input  busy, done, energy, row_rd_en, row_rd_addr, row_add_ena,
           sys_matrix, sys_add_ena
`ifdef ENERGY_MIN_TRACK_EN
    , input min_energy, min_update
`endif
  );
endinterface

// File: rtl/adder_sweep_scheduler.sv
// Sweep scheduler: walks all NUM_SPINS rows of the coupling/phase matrix
// through one shared row adder, buffers each row sum, then fires the system
// adder once and latches the sweep total as energy.
// Optional feature macro: ENERGY_MIN_TRACK_EN (running minimum of energy).
module adder_sweep_scheduler #(
  parameter int NUM_SPINS     = 64,
  parameter int NUM_SPINS_EXP = 6,
  parameter int IN_W          = 8,   // NL_OUT_PHASE_BITWIDTH
  parameter int ADD_LAT       = 1    // register latency of each adder, >= 1
) (
  input  logic                     clk,
  input  logic                     reset,
  adder_sweep_scheduler_if.master  bus
);
  localparam int ROW_W  = IN_W + NUM_SPINS_EXP;
  localparam int TOT_W  = IN_W + 2 * NUM_SPINS_EXP;
  localparam int WAIT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  localparam logic [NUM_SPINS_EXP-1:0] LAST_ADDR = NUM_SPINS_EXP'(NUM_SPINS - 1);
  localparam logic [WAIT_W-1:0]        WAIT_LAST = WAIT_W'(ADD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    SYS,
    WAIT_SYS,
    DONE
  } state_t;

  state_t                             state, state_nxt;
  logic [NUM_SPINS_EXP-1:0]           addr_cnt;
  logic [WAIT_W-1:0]                  wait_cnt;
  // Capture pipeline: stage 0 lines up with the memory data / row adder ena,
  // stage ADD_LAT lines up with the row adder result.
  logic [ADD_LAT:0]                   cap_vld;
  logic [ADD_LAT:0][NUM_SPINS_EXP-1:0] cap_idx;
  logic [NUM_SPINS-1:0][ROW_W-1:0]    sys_matrix_q;
  logic [TOT_W-1:0]                   energy_q;

  logic busy_c, done_c, rd_en_c, sys_ena_c;
  logic last_capture, sys_capture;

  assign last_capture = cap_vld[ADD_LAT] && (cap_idx[ADD_LAT] == LAST_ADDR);
  assign sys_capture  = (state == WAIT_SYS) && (wait_cnt == WAIT_LAST);

  // State register; reset has priority over start.
  always_ff @(posedge clk) begin
    // NOTE: state in clocked blocks uses <= so every register samples the
    // pre-edge values; a blocking = here would create order-dependent races.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-state strobes.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_nxt = state;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    rd_en_c   = 1'b0;
    sys_ena_c = 1'b0;
    unique case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_nxt = FETCH;
      end
      FETCH: begin
        rd_en_c = 1'b1;
        if (addr_cnt == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN:    if (last_capture) state_nxt = SYS;
      SYS: begin
        sys_ena_c = 1'b1;
        state_nxt = WAIT_SYS;
      end
      WAIT_SYS: if (sys_capture) state_nxt = DONE;
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Row address counter: cleared only when a sweep is launched, one step per
  // FETCH cycle, parked on the last row until the next launch.
  always_ff @(posedge clk) begin
    if (reset)                                    addr_cnt <= '0;
    else if (state == IDLE && bus.start)          addr_cnt <= '0;
    else if (state == FETCH && addr_cnt != LAST_ADDR) addr_cnt <= addr_cnt + 1'b1;
  end

  // Counts the system adder latency after the single SYS cycle.
  always_ff @(posedge clk) begin
    if (reset)                  wait_cnt <= '0;
    else if (state == SYS)      wait_cnt <= '0;
    else if (state == WAIT_SYS) wait_cnt <= wait_cnt + 1'b1;
  end

  // Valid/index shift chain tracking each read until its row sum appears.
  always_ff @(posedge clk) begin
    if (reset) cap_vld <= '0;
    else       cap_vld <= {cap_vld[ADD_LAT-1:0], rd_en_c};
  end

  // Index payload of the chain; only meaningful where cap_vld is set.
  always_ff @(posedge clk) begin
    cap_idx <= {cap_idx[ADD_LAT-1:0], bus.row_rd_addr};
  end

  // Row-sum buffer feeding the system adder.
  always_ff @(posedge clk) begin
    // NOTE: this buffer is a visible output that must read zero after reset,
    // so it is reset like any register; the index chain above is not, since
    // its contents are ignored until qualified by cap_vld.
    if (reset)                 sys_matrix_q <= '0;
    else if (cap_vld[ADD_LAT]) sys_matrix_q[cap_idx[ADD_LAT]] <= bus.row_sum;
  end

  // Sweep total, held until the next sweep's capture.
  always_ff @(posedge clk) begin
    if (reset)            energy_q <= '0;
    else if (sys_capture) energy_q <= bus.sys_sum;
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.row_rd_en   = rd_en_c;
  assign bus.row_rd_addr = rd_en_c ? addr_cnt : '0;
  assign bus.row_add_ena = cap_vld[0];
  assign bus.sys_add_ena = sys_ena_c;
  assign bus.sys_matrix  = sys_matrix_q;
  assign bus.energy      = energy_q;

`ifdef ENERGY_MIN_TRACK_EN
  logic [TOT_W-1:0] min_energy_q;
  logic             min_lower;

  // Strictly lower only: a tie keeps the stored minimum and raises no pulse.
  assign min_lower = (state == DONE) && (energy_q < min_energy_q);

  // Running minimum across sweeps; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)          min_energy_q <= '1;
    else if (min_lower) min_energy_q <= energy_q;
  end

  assign bus.min_energy = min_energy_q;
  assign bus.min_update = min_lower;
`endif

endmodule
